// File: rtl/i2c_target_responder.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte valid/ready handshake.
// Optional clock stretching on reads when I2C_TARGET_CLKSTRETCH_EN is defined.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       rw_o,
    output logic       busy_o
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_LOAD  = 3'd5;
    localparam logic [2:0] S_RD_DATA  = 3'd6;
    localparam logic [2:0] S_RD_ACK   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_q, sda_q;
    logic       scl_rise, scl_fall, start_det, stop_det, handshake;
    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       byte_done;

    // Synchronizers idle high so reset release never looks like a bus edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign handshake = tx_ready_o & tx_valid_i;

`ifdef I2C_TARGET_CLKSTRETCH_EN
    logic scl_oe;
    assign scl_oe_o = scl_oe;
`else
    assign scl_oe_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            byte_done  <= 1'b0;
            sda_oe_o   <= 1'b0;
            rx_data_o  <= 8'h00;
            rx_valid_o <= 1'b0;
            tx_ready_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            rw_o       <= 1'b0;
            busy_o     <= 1'b0;
`ifdef I2C_TARGET_CLKSTRETCH_EN
            scl_oe     <= 1'b0;
`endif
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            byte_done  <= 1'b0;
            rx_valid_o <= byte_done;
            if (byte_done) rx_data_o <= shreg;

            if (start_det) begin
                state      <= S_ADDR;
                bit_cnt    <= 4'd0;
                sda_oe_o   <= 1'b0;
                tx_ready_o <= 1'b0;
`ifdef I2C_TARGET_CLKSTRETCH_EN
                scl_oe     <= 1'b0;
`endif
            end else if (stop_det) begin
                state      <= S_IDLE;
                sda_oe_o   <= 1'b0;
                tx_ready_o <= 1'b0;
                stop_o     <= busy_o;
                busy_o     <= 1'b0;
`ifdef I2C_TARGET_CLKSTRETCH_EN
                scl_oe     <= 1'b0;
`endif
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda_s};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (shreg[6:0] == TARGET_ADDR) begin
                                rw_o   <= sda_s;
                                busy_o <= 1'b1;
                                state  <= S_ADDR_ACK;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // First fall after the 8th bit starts the ACK, the next one ends it
                    S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!sda_oe_o) begin
                            sda_oe_o <= 1'b1;
                            if (state == S_ADDR_ACK) start_o <= 1'b1;
                        end else begin
                            sda_oe_o <= 1'b0;
                            if (state == S_WR_ACK || !rw_o) begin
                                state <= S_WR_DATA;
                            end else begin
                                state      <= S_RD_LOAD;
                                tx_ready_o <= 1'b1;
`ifdef I2C_TARGET_CLKSTRETCH_EN
                                scl_oe     <= ~tx_valid_i;
`endif
                            end
                        end
                    end
                    S_WR_DATA: if (scl_rise) begin
                        shreg <= {shreg[6:0], sda_s};
                        if (bit_cnt == 4'd7) begin
                            bit_cnt   <= 4'd0;
                            byte_done <= 1'b1;
                            state     <= S_WR_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_RD_LOAD: begin
`ifndef I2C_TARGET_CLKSTRETCH_EN
                        // No data by the first data rise: send all-ones, drop a late byte
                        if (scl_rise) begin
                            shreg      <= 8'hFF;
                            sda_oe_o   <= 1'b0;
                            bit_cnt    <= 4'd1;
                            tx_ready_o <= ~tx_valid_i;
                            state      <= S_RD_DATA;
                        end else
`endif
                        if (handshake) begin
                            shreg      <= tx_data_i;
                            sda_oe_o   <= ~tx_data_i[7];
                            bit_cnt    <= 4'd0;
                            tx_ready_o <= 1'b0;
                            state      <= S_RD_DATA;
                        end
                    end
                    S_RD_DATA: begin
`ifdef I2C_TARGET_CLKSTRETCH_EN
                        scl_oe <= 1'b0;
`endif
                        if (handshake) tx_ready_o <= 1'b0;
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_o   <= 1'b0;
                                tx_ready_o <= 1'b0;
                                bit_cnt    <= 4'd0;
                                state      <= S_RD_ACK;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b1};
                                sda_oe_o <= ~shreg[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) state <= S_IDLE;
                            else bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            bit_cnt    <= 4'd0;
                            tx_ready_o <= 1'b1;
                            state      <= S_RD_LOAD;
`ifdef I2C_TARGET_CLKSTRETCH_EN
                            scl_oe     <= ~tx_valid_i;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged open-drain master, tx feeder and
// transaction-level expectations (address match -> ACKs, bytes, pulse counts).
module tb_i2c_target_responder;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic m_scl_low = 1'b0, m_sda_low = 1'b0;
    logic scl_bus, sda_bus;
    logic scl_oe_o, sda_oe_o, rx_valid_o, tx_ready_o, start_o, stop_o, rw_o, busy_o;
    logic [7:0] rx_data_o;
    logic [7:0] tx_data_i = 8'h00;
    logic tx_valid_i = 1'b0;

    assign scl_bus = ~(m_scl_low | scl_oe_o);
    assign sda_bus = ~(m_sda_low | sda_oe_o);

    i2c_target_responder dut (
        .clk_i(clk), .rst_ni(rst_ni), .scl_i(scl_bus), .sda_i(sda_bus),
        .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .start_o(start_o), .stop_o(stop_o), .rw_o(rw_o), .busy_o(busy_o)
    );

    int checks = 0, failures = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor
    int start_cnt = 0, stop_cnt = 0, busy_cnt = 0, oe_cnt = 0;
    logic [7:0] rx_got[$];
    always @(negedge clk) begin
        if (rx_valid_o) rx_got.push_back(rx_data_o);
        if (start_o) start_cnt++;
        if (stop_o) stop_cnt++;
        if (busy_o) busy_cnt++;
        if (sda_oe_o) oe_cnt++;
    end

    // tx byte source: offers the queue head tx_delay cycles after tx_ready_o rises
    logic [7:0] tx_q[$];
    int tx_delay = 0;
    int dly_cnt = 0;
    bit hs_prev = 1'b0;
    always @(negedge clk) begin
        if (hs_prev) begin
            if (tx_q.size() > 0) void'(tx_q.pop_front());
            tx_valid_i = 1'b0;
            dly_cnt = 0;
        end
        if (!tx_valid_i && tx_q.size() > 0 && tx_ready_o) begin
            if (dly_cnt >= tx_delay) begin
                tx_valid_i = 1'b1;
                tx_data_i = tx_q[0];
            end else dly_cnt++;
        end
        hs_prev = tx_valid_i & tx_ready_o;
    end

    int max_stretch = 0;
    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic scl_release();
        int w;
        w = 0;
        m_scl_low = 1'b0;
        #1;
        while (!scl_bus && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (!scl_bus) chk("scl_release_timeout", scl_bus, 1);
        if (w > max_stretch) max_stretch = w;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wq();
        scl_release(); wq();
        m_sda_low = 1'b1; wq();
        m_scl_low = 1'b1; wq();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wq();
        scl_release(); wq();
        m_sda_low = 1'b0; wq(); wq();
    endtask

    task automatic i2c_bit(input bit b, output bit r);
        m_sda_low = ~b; wq();
        scl_release(); wq();
        r = sda_bus; wq();
        m_scl_low = 1'b1; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic read_byte(input bit nack, output logic [7:0] b);
        bit r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            b[i] = r;
        end
        i2c_bit(nack, r);
    endtask

    // Write transaction; expectations follow from whether the address matches
    task automatic do_write(input logic [6:0] a, input int n, input logic [7:0] d[4]);
        bit ack, m;
        int s0, p0, r0, b0, o0;
        logic [7:0] exp_q[$];
        m = (a == 7'h22);
        s0 = start_cnt; p0 = stop_cnt; r0 = rx_got.size(); b0 = busy_cnt; o0 = oe_cnt;
        i2c_start();
        write_byte({a, 1'b0}, ack);
        chk("wr_addr_ack", ack, !m);
        if (m) begin
            for (int i = 0; i < n; i++) begin
                write_byte(d[i], ack);
                chk("wr_data_ack", ack, 0);
                exp_q.push_back(d[i]);
            end
        end
        i2c_stop();
        wq();
        chk("wr_rx_count", rx_got.size() - r0, exp_q.size());
        for (int i = 0; i < exp_q.size() && r0 + i < rx_got.size(); i++)
            chk("wr_rx_data", rx_got[r0+i], exp_q[i]);
        chk("wr_start_pulses", start_cnt - s0, m);
        chk("wr_stop_pulses", stop_cnt - p0, m);
        chk("wr_busy_seen", busy_cnt > b0, m);
        chk("wr_sda_driven", oe_cnt > o0, m);
        chk("wr_busy_end", busy_o, 0);
    endtask

    // Read transaction of n bytes: d supplied on tx, e expected on the bus
    task automatic do_read(input int n, input logic [7:0] d[4], input logic [7:0] e[4], input int dly);
        bit ack;
        int s0, p0, r0;
        logic [7:0] b;
        s0 = start_cnt; p0 = stop_cnt; r0 = rx_got.size();
        tx_delay = dly;
        for (int i = 0; i < n; i++) tx_q.push_back(d[i]);
        max_stretch = 0;
        i2c_start();
        write_byte({7'h22, 1'b1}, ack);
        chk("rd_addr_ack", ack, 0);
        chk("rd_rw", rw_o, 1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            chk("rd_data", b, e[i]);
        end
        wq();
        chk("rd_release_after_nack", sda_oe_o, 0);
        chk("rd_busy_before_stop", busy_o, 1);
        i2c_stop();
        wq();
        chk("rd_start_pulses", start_cnt - s0, 1);
        chk("rd_stop_pulses", stop_cnt - p0, 1);
        chk("rd_no_rx", rx_got.size() - r0, 0);
        chk("rd_busy_end", busy_o, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0] d[4], e[4];
        logic [7:0] b;
        bit ack, r;
        int s0, p0, r0, n;
        logic [6:0] a;

        repeat (5) @(negedge clk);
        chk("rst_scl_oe", scl_oe_o, 0);
        chk("rst_sda_oe", sda_oe_o, 0);
        chk("rst_rx_data", rx_data_o, 8'h00);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_stop", stop_o, 0);
        chk("rst_rw", rw_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);

        d = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        do_write(7'h22, 2, d);
        do_write(7'h23, 2, d);

        d = '{8'h81, 8'h7E, 8'h00, 8'h00};
        do_read(2, d, d, 0);

        // Late tx byte
        d = '{8'h55, 8'h00, 8'h00, 8'h00};
`ifdef I2C_TARGET_CLKSTRETCH_EN
        do_read(1, d, d, 200);
        chk("stretch_long", max_stretch > 150, 1);
`else
        e = '{8'hFF, 8'h00, 8'h00, 8'h00};
        do_read(1, d, e, 200);
        chk("no_stretch", max_stretch, 0);
`endif

        // Repeated START after a partial write byte
        s0 = start_cnt; p0 = stop_cnt; r0 = rx_got.size();
        i2c_start();
        write_byte(8'h44, ack);
        chk("rs_wr_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) i2c_bit(1'($urandom_range(0, 1)), r);
        i2c_start();
        tx_delay = 0;
        tx_q.push_back(8'h96);
        write_byte(8'h45, ack);
        chk("rs_rd_addr_ack", ack, 0);
        chk("rs_rw", rw_o, 1);
        read_byte(1'b1, b);
        chk("rs_rd_data", b, 8'h96);
        i2c_stop();
        wq();
        chk("rs_no_rx", rx_got.size() - r0, 0);
        chk("rs_start_pulses", start_cnt - s0, 2);
        chk("rs_stop_pulses", stop_cnt - p0, 1);

        // Randomized transactions
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                a = 7'h22;
                if ($urandom_range(0, 3) == 0) begin
                    a = 7'($urandom);
                    if (a == 7'h22) a = 7'h5A;
                end
                do_write(a, n, d);
            end else begin
                do_read(n, d, d, $urandom_range(0, 3));
            end
        end

        // Reset while the target drives a zero data bit
        tx_delay = 0;
        tx_q.push_back(8'h00);
        i2c_start();
        write_byte(8'h45, ack);
        chk("rr_addr_ack", ack, 0);
        repeat (4) @(negedge clk);
        chk("rr_pre_sda_oe", sda_oe_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rr_sda_oe", sda_oe_o, 0);
        chk("rr_scl_oe", scl_oe_o, 0);
        chk("rr_rx_data", rx_data_o, 8'h00);
        chk("rr_tx_ready", tx_ready_o, 0);
        chk("rr_busy", busy_o, 0);
        chk("rr_rw", rw_o, 0);
        chk("rr_start_stop", {start_o, stop_o, rx_valid_o}, 0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        i2c_stop();
        d = '{8'hC3, 8'h00, 8'h00, 8'h00};
        do_write(7'h22, 1, d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
